// File: rtl/spm_seq.sv
// spm_seq: handshaked serial-parallel multiplier with a carry-save chain.
// Signed or unsigned operands; the product is streamed LSB first and also collected in parallel.
module spm_seq #(
  parameter int XW = 32,
  parameter int YW = 32,
  parameter int PW = XW + YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sgn,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          abort,
  output logic          busy,
  output logic          p,
  output logic          p_valid,
  output logic          done,
  output logic [PW-1:0] product
);
  localparam int W = XW + 1;
  localparam int KW = $clog2(PW + 1);
  localparam logic [KW-1:0] K_LAST = KW'(PW - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_x, r_s, r_c;
  logic [YW:0] r_y;
  logic [KW-1:0] r_k;
  logic r_p;
  logic [PW-1:0] r_product;
  logic w_run, w_load;
  logic [W-1:0] w_xe, w_s, w_c, w_pp, w_sum, w_maj;
  logic [YW:0] w_yl;
  logic [PW-1:0] w_mask;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_run = r_state == S_RUN;
    w_load = start & ~w_run;
    w_next = w_load ? S_RUN : w_run ? (abort ? S_IDLE : (r_k == K_LAST ? S_DONE : S_RUN)) : S_IDLE;
    busy = w_run;
    p_valid = w_run;
    done = r_state == S_DONE;
    p = w_run & r_p;
  end
  // The x stage above the MSB carries x's sign, so the MSB stage acts as the two's-complement stage
  always_comb begin
    w_xe = w_load ? {sgn & x[XW-1], x} : r_x;
    w_yl = w_load ? {sgn & y[YW-1], y} : r_y;
    w_s = w_load ? '0 : r_s;
    w_c = w_load ? '0 : r_c;
    w_pp = w_yl[0] ? w_xe : '0;
    w_sum = w_s ^ w_c ^ w_pp;
    w_maj = (w_s & w_c) | (w_s & w_pp) | (w_c & w_pp);
    w_mask = PW'(1) << r_k;
  end
  // Sum shifts down arithmetically and carries stay put, keeping s+c exact in two's complement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= '0;
      r_s <= '0;
      r_c <= '0;
      r_y <= '0;
      r_k <= '0;
      r_p <= 1'b0;
      r_product <= '0;
    end else if (w_load || w_run) begin
      r_x <= w_xe;
      r_s <= {w_sum[W-1], w_sum[W-1:1]};
      r_c <= w_maj;
      r_y <= {w_yl[YW], w_yl[YW:1]};
      r_p <= w_sum[0];
      r_k <= w_load ? '0 : r_k + KW'(1);
      r_product <= w_load ? '0 : (r_product | (r_p ? w_mask : '0));
    end
  end
  assign product = r_product;
endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: directed checks of spm_seq at 32x32 and 8x4 operand widths.
module tb_spm_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic a_start = 0, a_sgn = 0, a_abort = 0, a_busy, a_p, a_pv, a_done;
  logic [31:0] a_x = 0, a_y = 0;
  logic [63:0] a_prod;
  logic b_start = 0, b_sgn = 0, b_abort = 0, b_busy, b_p, b_pv, b_done;
  logic [7:0] b_x = 0;
  logic [3:0] b_y = 0;
  logic [11:0] b_prod;
  int checks = 0, failures = 0;

  spm_seq #(.XW(32), .YW(32)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .sgn(a_sgn), .x(a_x), .y(a_y), .abort(a_abort),
    .busy(a_busy), .p(a_p), .p_valid(a_pv), .done(a_done), .product(a_prod)
  );
  spm_seq #(.XW(8), .YW(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .sgn(b_sgn), .x(b_x), .y(b_y), .abort(b_abort),
    .busy(b_busy), .p(b_p), .p_valid(b_pv), .done(b_done), .product(b_prod)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({a_busy, a_p, a_pv, a_done, a_prod} !== 68'd0) begin
      failures++;
      $display("FAIL reset_a got busy=%b p=%b pv=%b done=%b prod=%h exp all 0", a_busy, a_p, a_pv, a_done, a_prod);
    end
    checks++;
    if ({b_busy, b_p, b_pv, b_done, b_prod} !== 16'd0) begin
      failures++;
      $display("FAIL reset_b got busy=%b p=%b pv=%b done=%b prod=%h exp all 0", b_busy, b_p, b_pv, b_done, b_prod);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic run32(input logic [31:0] xa, input logic [31:0] ya, input logic s, input logic [63:0] exp, input string nm);
    logic [63:0] ser;
    int bad;
    ser = '0;
    bad = 0;
    a_x = xa; a_y = ya; a_sgn = s; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (a_pv !== 1'b1 || a_busy !== 1'b1 || a_done !== 1'b0) bad++;
      ser[k] = a_p;
      tick();
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_pv !== 1'b0 || a_p !== 1'b0) begin
      failures++;
      $display("FAIL %s_done65 got done=%b busy=%b pv=%b p=%b exp 1 0 0 0", nm, a_done, a_busy, a_pv, a_p);
    end
    checks++;
    if (ser !== exp) begin
      failures++;
      $display("FAIL %s_serial got %h exp %h", nm, ser, exp);
    end
    checks++;
    if (a_prod !== exp) begin
      failures++;
      $display("FAIL %s_product got %h exp %h", nm, a_prod, exp);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s_run_flags got %0d bad cycles exp 0", nm, bad);
    end
    tick();
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_pv !== 1'b0 || a_prod !== exp) begin
      failures++;
      $display("FAIL %s_after got done=%b busy=%b pv=%b prod=%h exp 0 0 0 %h", nm, a_done, a_busy, a_pv, a_prod, exp);
    end
  endtask

  task automatic run8(input logic [7:0] xa, input logic [3:0] ya, input logic s, input logic [11:0] exp, input string nm);
    logic [11:0] ser;
    int bad;
    ser = '0;
    bad = 0;
    b_x = xa; b_y = ya; b_sgn = s; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (b_pv !== 1'b1 || b_busy !== 1'b1 || b_done !== 1'b0) bad++;
      ser[k] = b_p;
      tick();
    end
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_pv !== 1'b0) begin
      failures++;
      $display("FAIL %s_done13 got done=%b busy=%b pv=%b exp 1 0 0", nm, b_done, b_busy, b_pv);
    end
    checks++;
    if (ser !== exp) begin
      failures++;
      $display("FAIL %s_serial got %h exp %h", nm, ser, exp);
    end
    checks++;
    if (b_prod !== exp) begin
      failures++;
      $display("FAIL %s_product got %h exp %h", nm, b_prod, exp);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s_run_flags got %0d bad cycles exp 0", nm, bad);
    end
    tick();
  endtask

  task automatic test_unsigned32();
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "u32_max");
    run32(32'h00010001, 32'h0000FFFF, 1'b0, 64'h00000000FFFFFFFF, "u32_mix");
  endtask

  task automatic test_signed32();
    run32(32'hFFFFFFFF, 32'h80000000, 1'b1, 64'h0000000080000000, "s32_m1");
    run32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "s32_min");
  endtask

  task automatic test_asym();
    run8(8'h85, 4'hB, 1'b0, 12'h5B7, "u8x4");
    run8(8'h85, 4'hB, 1'b1, 12'h267, "s8x4");
  endtask

  task automatic test_back_to_back();
    int nd;
    nd = 0;
    a_x = 32'd7; a_y = 32'd9; a_sgn = 1'b0; a_start = 1'b1;
    tick();
    for (int c = 1; c < 65; c++) begin
      a_start = (c == 5 || c == 20);
      if (c == 5 || c == 20) begin
        a_x = 32'd1; a_y = 32'd1;
      end
      if (a_done) nd++;
      tick();
    end
    checks++;
    if (a_done !== 1'b1 || nd !== 0 || a_prod !== 64'd63) begin
      failures++;
      $display("FAIL ignore_start got done=%b early_dones=%0d prod=%h exp 1 0 %h", a_done, nd, a_prod, 64'd63);
    end
    a_x = 32'd2; a_y = 32'd3; a_start = 1'b1;
    tick();
    checks++;
    if (a_pv !== 1'b1 || a_busy !== 1'b1 || a_done !== 1'b0 || a_prod !== 64'd0) begin
      failures++;
      $display("FAIL b2b_accept got pv=%b busy=%b done=%b prod=%h exp 1 1 0 0", a_pv, a_busy, a_done, a_prod);
    end
    a_start = 1'b0;
    nd = 0;
    for (int c = 0; c < 64; c++) begin
      if (a_done) nd++;
      tick();
    end
    checks++;
    if (a_done !== 1'b1 || nd !== 0 || a_prod !== 64'd6) begin
      failures++;
      $display("FAIL b2b_second got done=%b early_dones=%0d prod=%h exp 1 0 %h", a_done, nd, a_prod, 64'd6);
    end
    tick();
  endtask

  task automatic test_abort();
    int nd;
    nd = 0;
    a_x = 32'd5; a_y = 32'd7; a_sgn = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_pv !== 1'b0 || a_done !== 1'b0 || a_p !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b pv=%b done=%b p=%b exp 0 0 0 0", a_busy, a_pv, a_done, a_p);
    end
    for (int c = 0; c < 70; c++) begin
      if (a_done || a_busy) nd++;
      tick();
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d done/busy cycles exp 0", nd);
    end
    run32(32'h00010001, 32'h0000FFFF, 1'b0, 64'h00000000FFFFFFFF, "post_abort");
  endtask

  task automatic test_reset_mid();
    a_x = 32'hFFFFFFFF; a_y = 32'hFFFFFFFF; a_sgn = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (16) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_p, a_pv, a_done, a_prod} !== 68'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b p=%b pv=%b done=%b prod=%h exp all 0", a_busy, a_p, a_pv, a_done, a_prod);
    end
    tick();
    rst = 1'b1;
    tick();
    run32(32'd3, 32'd5, 1'b0, 64'd15, "post_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned32();
    test_signed32();
    test_asym();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
